// File: rtl/bmu_arbiter.sv
// bmu_arbiter: round-robin sharing of a single BMU among NUM_REQ requesters.
// Screens non-one-hot control vectors locally and returns results over a per-requester valid/ready response.
module bmu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AP_W    = 22,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ*AP_W-1:0] req_ap,
    output logic                    bmu_valid,
    output logic [31:0]             bmu_a,
    output logic [31:0]             bmu_b,
    output logic [AP_W-1:0]         bmu_ap,
    input  logic [31:0]             bmu_result,
    input  logic                    bmu_error,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    rsp_error,
    output logic [CNT_W-1:0]        ops_issued
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] owner_r;
    logic             grant_vld_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] cand_s;
    logic [31:0]      a_arr_s  [NUM_REQ];
    logic [31:0]      b_arr_s  [NUM_REQ];
    logic [AP_W-1:0]  ap_arr_s [NUM_REQ];

    function automatic logic is_onehot(input logic [AP_W-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < AP_W; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return (cnt == 1);
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return IDX_W'((int'(idx) + 1) % NUM_REQ);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr_s[i]  = req_a[32*i +: 32];
        assign b_arr_s[i]  = req_b[32*i +: 32];
        assign ap_arr_s[i] = req_ap[AP_W*i +: AP_W];
    end

    // Round-robin search from rr_ptr_r; scanning offsets downward leaves the nearest valid requester as winner.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (req_valid[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Accept is offered only while idle, so a handshake coincides with grant_vld_s in IDLE.
    always_comb begin
        if ((state_r == IDLE) && grant_vld_s) begin
            req_ready = idx_onehot(grant_idx_s);
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Sequencer: accept, drive the BMU for one cycle, capture its result, hold the response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= {IDX_W{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            bmu_valid  <= 1'b0;
            bmu_a      <= 32'd0;
            bmu_b      <= 32'd0;
            bmu_ap     <= {AP_W{1'b0}};
            rsp_valid  <= {NUM_REQ{1'b0}};
            rsp_data   <= 32'd0;
            rsp_error  <= 1'b0;
            ops_issued <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_vld_s) begin
                        owner_r  <= grant_idx_s;
                        rr_ptr_r <= next_ptr(grant_idx_s);
                        if (is_onehot(ap_arr_s[grant_idx_s])) begin
                            state_r   <= ISSUE;
                            bmu_valid <= 1'b1;
                            bmu_a     <= a_arr_s[grant_idx_s];
                            bmu_b     <= b_arr_s[grant_idx_s];
                            bmu_ap    <= ap_arr_s[grant_idx_s];
                        end else begin
                            // Malformed control vector never reaches the BMU.
                            state_r   <= RESP;
                            rsp_valid <= idx_onehot(grant_idx_s);
                            rsp_data  <= 32'd0;
                            rsp_error <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r   <= CAPTURE;
                    bmu_valid <= 1'b0;
                    bmu_a     <= 32'd0;
                    bmu_b     <= 32'd0;
                    bmu_ap    <= {AP_W{1'b0}};
                    if (ops_issued != {CNT_W{1'b1}}) begin
                        ops_issued <= ops_issued + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        ops_issued <= ops_issued;
                    end
                end
                CAPTURE: begin
                    state_r   <= RESP;
                    rsp_valid <= idx_onehot(owner_r);
                    rsp_data  <= bmu_result;
                    rsp_error <= bmu_error;
                end
                RESP: begin
                    if (rsp_ready[owner_r]) begin
                        state_r   <= IDLE;
                        rsp_valid <= {NUM_REQ{1'b0}};
                        rsp_data  <= 32'd0;
                        rsp_error <= 1'b0;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bmu_valid <= 1'b0;
                    rsp_valid <= {NUM_REQ{1'b0}};
                    rsp_data  <= 32'd0;
                    rsp_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmu_arbiter.sv
// Bench for bmu_arbiter: behavioural BMU, round-robin reference model and a response scoreboard.
module tb_bmu_arbiter;
    localparam logic [21:0] AP_ADD  = 22'h001000;
    localparam logic [21:0] AP_SUB  = 22'h000800;
    localparam logic [21:0] AP_SLT  = 22'h000400;
    localparam logic [21:0] AP_LAND = 22'h020000;
    localparam logic [21:0] AP_LXOR = 22'h008000;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [21:0] ap;
        int          due;
    } iss_t;

    logic         clk, rst;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_a, req_b;
    logic [87:0]  req_ap;
    logic         bmu_valid, bmu_error, rsp_error;
    logic [31:0]  bmu_a, bmu_b, bmu_result, rsp_data;
    logic [21:0]  bmu_ap;
    logic [15:0]  ops_issued;
    logic [3:0]   req_ready2, rsp_valid2;
    logic         bmu_valid2, rsp_error2;
    logic [31:0]  bmu_a2, bmu_b2, rsp_data2;
    logic [21:0]  bmu_ap2;
    logic [1:0]   ops2;

    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   exp_ptr = 0;
    int   t_start, base, ops_before;
    logic rsp_seen = 1'b0;
    logic [31:0] last_data;
    logic        last_err;
    exp_t exp_q[$];
    iss_t iss_q[$];
    int   g_q[$];
    int   hs_q[$];

    bmu_arbiter #(.NUM_REQ(4), .AP_W(22), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ap(req_ap),
        .bmu_valid(bmu_valid), .bmu_a(bmu_a), .bmu_b(bmu_b), .bmu_ap(bmu_ap),
        .bmu_result(bmu_result), .bmu_error(bmu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .ops_issued(ops_issued)
    );

    bmu_arbiter #(.NUM_REQ(4), .AP_W(22), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_ap(req_ap),
        .bmu_valid(bmu_valid2), .bmu_a(bmu_a2), .bmu_b(bmu_b2), .bmu_ap(bmu_ap2),
        .bmu_result(bmu_result), .bmu_error(bmu_error),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
        .rsp_error(rsp_error2), .ops_issued(ops2)
    );

    function automatic logic [32:0] bmu_fn(input logic [31:0] a, input logic [31:0] b, input logic [21:0] ap);
        logic [31:0] r;
        logic        e;
        r = 32'd0;
        e = 1'b0;
        case (ap)
            AP_ADD:  begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
            AP_SUB:  begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
            AP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            AP_LAND: r = a & b;
            AP_LXOR: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {e, r};
    endfunction

    function automatic int model_grant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [21:0] ap);
        req_a[32*idx +: 32]  = a;
        req_b[32*idx +: 32]  = b;
        req_ap[22*idx +: 22] = ap;
    endtask

    task automatic wait_hs(input int start, input int n, input int bound);
        for (int i = 0; i < bound && (hs_cnt - start) < n; i++) tick();
        check("hs_count", 32'(hs_cnt - start), 32'(n));
    endtask

    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [21:0] ap);
        int start;
        start = hs_cnt;
        set_op(idx, a, b, ap);
        req_valid[idx] = 1'b1;
        wait_hs(start, 1, 20);
        req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural BMU: result_ff/error register the op presented with valid_in.
    initial begin
        bmu_result = 32'd0;
        bmu_error  = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (bmu_valid) {bmu_error, bmu_result} <= bmu_fn(bmu_a, bmu_b, bmu_ap);
        end
    end

    // Monitor on the falling edge: grant model, BMU-drive checks and response scoreboard.
    initial begin
        int   g;
        exp_t e;
        iss_t it;
        logic [21:0] eap;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                iss_q.delete();
                exp_ptr  = 0;
                rsp_seen = 1'b0;
            end else begin
                if ((req_valid & req_ready) != 4'd0) begin
                    g = model_grant(req_valid, exp_ptr);
                    check("grant", 32'(req_ready), oh(g));
                    eap     = req_ap[22*g +: 22];
                    e.owner = g;
                    if ($countones(eap) == 1) begin
                        {e.err, e.data} = bmu_fn(req_a[32*g +: 32], req_b[32*g +: 32], eap);
                        e.due = cyc + 3;
                        it.a  = req_a[32*g +: 32];
                        it.b  = req_b[32*g +: 32];
                        it.ap = eap;
                        it.due = cyc + 1;
                        iss_q.push_back(it);
                    end else begin
                        e.data = 32'd0;
                        e.err  = 1'b1;
                        e.due  = cyc + 1;
                    end
                    exp_q.push_back(e);
                    g_q.push_back(g);
                    hs_q.push_back(cyc);
                    hs_cnt  = hs_cnt + 1;
                    exp_ptr = (g + 1) % 4;
                end
                if (bmu_valid) begin
                    if (iss_q.size() == 0) begin
                        check("bmu_spurious", 32'(bmu_valid), 32'd0);
                    end else begin
                        it = iss_q.pop_front();
                        check("bmu_lat", 32'(cyc), 32'(it.due));
                        check("bmu_a", bmu_a, it.a);
                        check("bmu_b", bmu_b, it.b);
                        check("bmu_ap", 32'(bmu_ap), 32'(it.ap));
                    end
                end else begin
                    check("bmu_idle", bmu_a | bmu_b | {10'd0, bmu_ap}, 32'd0);
                end
                if (rsp_valid != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_spurious", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        if (!rsp_seen) begin
                            check("rsp_lat", 32'(cyc), 32'(e.due));
                            rsp_seen = 1'b1;
                        end
                        check("rsp_owner", 32'(rsp_valid), oh(e.owner));
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_error", 32'(rsp_error), 32'(e.err));
                        if ((rsp_valid & rsp_ready) != 4'd0) begin
                            void'(exp_q.pop_front());
                            last_data = rsp_data;
                            last_err  = rsp_error;
                            rsp_seen  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_miss %0d", n_miss);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'd0;
        rsp_ready = 4'hF;
        req_a     = 128'd0;
        req_b     = 128'd0;
        req_ap    = 88'd0;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_bmu", {31'd0, bmu_valid} | bmu_a | bmu_b | {10'd0, bmu_ap}, 32'd0);
        check("rst_rsp", {27'd0, rsp_error, rsp_valid} | rsp_data, 32'd0);
        check("rst_ops", 32'(ops_issued), 32'd0);
        rst = 1'b0;
        tick();

        // Basic add on requester 0, then overflow forwarded on requester 1.
        send(0, 32'd5, 32'd7, AP_ADD);
        drain();
        check("t1_data", last_data, 32'd12);
        check("t1_err", 32'(last_err), 32'd0);
        check("t1_ops", 32'(ops_issued), 32'd1);
        send(1, 32'h7FFFFFFF, 32'd1, AP_ADD);
        drain();
        check("t2_data", last_data, 32'h80000000);
        check("t2_err", 32'(last_err), 32'd1);

        // All four requesters held valid from rr_ptr 0.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 32'(100 * i + 1), 32'(i + 2), (i == 2) ? AP_SUB : AP_ADD);
        base    = g_q.size();
        t_start = hs_cnt;
        req_valid = 4'hF;
        wait_hs(t_start, 5, 40);
        req_valid = 4'd0;
        drain();
        for (int i = 0; i < 5; i++) check("t3_order", 32'(g_q[base + i]), 32'(i % 4));
        for (int i = 1; i < 5; i++) check("t3_spacing", 32'(hs_q[base + i] - hs_q[base + i - 1]), 32'd4);
        check("t3_ops", 32'(ops_issued), 32'd5);

        // Non-one-hot control vectors are answered locally.
        ops_before = int'(ops_issued);
        send(2, 32'hF0F0F0F0, 32'h0FF00FF0, AP_LAND | AP_LXOR);
        drain();
        check("t4_data", last_data, 32'd0);
        check("t4_err", 32'(last_err), 32'd1);
        send(2, 32'd1, 32'd2, 22'd0);
        drain();
        check("t4_err_ap0", 32'(last_err), 32'd1);
        check("t4_ops", 32'(ops_issued), 32'(ops_before));

        // Stalled response on requester 3 blocks the pending requester 0.
        rsp_ready = 4'b0001;
        set_op(3, 32'hFFFFFFFF, 32'd0, AP_SLT);
        set_op(0, 32'd3, 32'd4, AP_ADD);
        t_start   = hs_cnt;
        req_valid = 4'b1001;
        wait_hs(t_start, 1, 20);
        check("t5_grant", 32'(g_q[$]), 32'd3);
        req_valid[3] = 1'b0;
        for (int i = 0; i < 10 && rsp_valid[3] !== 1'b1; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 32'(rsp_valid), 32'd8);
            check("t5_hold_data", rsp_data, 32'd1);
            check("t5_no_grant", 32'(req_ready), 32'd0);
            tick();
        end
        t_start   = hs_cnt;
        rsp_ready = 4'hF;
        wait_hs(t_start, 1, 20);
        check("t5_next_grant", 32'(g_q[$]), 32'd0);
        req_valid = 4'd0;
        drain();
        check("t5_last", last_data, 32'd7);

        // Reset while the op is in CAPTURE discards it.
        send(1, 32'd9, 32'd9, AP_ADD);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_bmu", {31'd0, bmu_valid} | bmu_a | bmu_b | {10'd0, bmu_ap}, 32'd0);
        check("t6_rsp", {27'd0, rsp_error, rsp_valid} | rsp_data, 32'd0);
        check("t6_ops", 32'(ops_issued), 32'd0);
        check("t6_ops_sat", 32'(ops2), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_op(1, 32'd20, 32'd22, AP_ADD);
        set_op(2, 32'd30, 32'd33, AP_ADD);
        t_start   = hs_cnt;
        req_valid = 4'b0110;
        wait_hs(t_start, 1, 20);
        req_valid = 4'd0;
        check("t6_ptr0", 32'(g_q[$]), 32'd1);
        drain();
        check("t6_data", last_data, 32'd42);
        for (int i = 0; i < 4; i++) begin
            send(0, 32'(i), 32'd1, AP_ADD);
            drain();
        end
        check("t6_ops5", 32'(ops_issued), 32'd5);
        check("t6_sat", 32'(ops2), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
